ftdi_frame_packer: RTL and testbench

//   Consumes the byte stream read from the FT245 sync FIFO on clk_60, frames it with a two-byte sync

---
 rtl/ftdi_pkg.sv | 17 +
 rtl/ftdi_word_assembler.sv | 38 +++
 rtl/ftdi_frame_packer.sv | 137 +++++++++++++
 tb/tb_ftdi_frame_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and defaults for the FT245 frame packer: FSM state encoding, sync bytes, widths.
package ftdi_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_e;

  localparam logic [7:0] DEF_SYNC0  = 8'hA5;
  localparam logic [7:0] DEF_SYNC1  = 8'h5A;
  localparam int         DEF_DATA_W = 20;
  localparam int         DEF_ADDR_W = 14;
  localparam int         PIX_W      = 20;

endpackage

// File: rtl/ftdi_word_assembler.sv
// Collects three little-endian bytes into a 20-bit pixel; flags the word when the top nibble of
// the third byte is non-zero. Word/valid/bad are presented combinationally on the completing byte.
module ftdi_word_assembler
  import ftdi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_byte_i,
  output logic [PIX_W-1:0] word_o,
  output logic             word_vld_o,
  output logic             word_bad_o
);

  logic [1:0]  idx_q;
  logic [15:0] lo_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= 2'd0;
      lo_q  <= 16'd0;
    end else if (clr_i) begin
      idx_q <= 2'd0;
    end else if (in_valid_i) begin
      case (idx_q)
        2'd0:    begin lo_q[7:0]  <= in_byte_i; idx_q <= 2'd1; end
        2'd1:    begin lo_q[15:8] <= in_byte_i; idx_q <= 2'd2; end
        default: idx_q <= 2'd0;
      endcase
    end
  end

  assign word_o     = {in_byte_i[3:0], lo_q};
  assign word_vld_o = in_valid_i && !clr_i && (idx_q == 2'd2);
  assign word_bad_o = (in_byte_i[7:4] != 4'h0);

endmodule

// File: rtl/ftdi_frame_packer.sv
// Frames the FT245 byte stream (sync header, 3-byte pixels) into framebuffer writes and flips the
// double-buffer bank on each accepted frame. FTDI_PACKER_CHECKSUM_EN adds a trailing XOR check byte.
module ftdi_frame_packer
  import ftdi_pkg::*;
#(
  parameter int         WORDS  = 16384,
  parameter int         DATA_W = DEF_DATA_W,
  parameter int         ADDR_W = DEF_ADDR_W,
  parameter logic [7:0] SYNC0  = DEF_SYNC0,
  parameter logic [7:0] SYNC1  = DEF_SYNC1
) (
  input  logic              clk_60,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] fb_wdata,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic              fb_we,
  output logic              fb_sel,
  output logic              frame_done,
  output logic              frame_err
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   fb_wdata_q;
  logic [ADDR_W-1:0]   fb_waddr_q;
  logic                fb_we_q, fb_sel_q, frame_done_q, frame_err_q;
  logic                done_pend_q;
`ifdef FTDI_PACKER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic [PIX_W-1:0]    asm_word;
  logic                asm_vld, asm_bad;
  logic                last_word;

  ftdi_word_assembler u_asm (
    .clk_i      (clk_60),
    .rst_i      (rst),
    .clr_i      (state_q != PAYLOAD),
    .in_valid_i (byte_valid),
    .in_byte_i  (byte_data),
    .word_o     (asm_word),
    .word_vld_o (asm_vld),
    .word_bad_o (asm_bad)
  );

  assign last_word = (addr_q == ADDR_W'(WORDS - 1));

  always_ff @(posedge clk_60 or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      addr_q       <= '0;
      fb_wdata_q   <= '0;
      fb_waddr_q   <= '0;
      fb_we_q      <= 1'b0;
      fb_sel_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      done_pend_q  <= 1'b0;
`ifdef FTDI_PACKER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      done_pend_q  <= 1'b0;
      // Acceptance lands one cycle after the final write strobe.
      if (done_pend_q) begin
        frame_done_q <= 1'b1;
        fb_sel_q     <= ~fb_sel_q;
      end
      if (byte_valid) begin
        case (state_q)
          HUNT: if (byte_data == SYNC0) state_q <= SYNC;
          SYNC: begin
            if (byte_data == SYNC1) begin
              state_q <= PAYLOAD;
              addr_q  <= '0;
`ifdef FTDI_PACKER_CHECKSUM_EN
              csum_q  <= 8'd0;
`endif
            end else if (byte_data != SYNC0) begin
              state_q <= HUNT;
            end
          end
          PAYLOAD: begin
`ifdef FTDI_PACKER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
            if (asm_vld) begin
              if (asm_bad) begin
                frame_err_q <= 1'b1;
                state_q     <= HUNT;
              end else begin
                fb_we_q    <= 1'b1;
                fb_waddr_q <= addr_q;
                fb_wdata_q <= DATA_W'(asm_word);
                addr_q     <= addr_q + 1'b1;
                if (last_word) begin
`ifdef FTDI_PACKER_CHECKSUM_EN
                  state_q     <= CHECK;
`else
                  state_q     <= HUNT;
                  done_pend_q <= 1'b1;
`endif
                end
              end
            end
          end
`ifdef FTDI_PACKER_CHECKSUM_EN
          CHECK: begin
            state_q <= HUNT;
            if (byte_data == csum_q) begin
              frame_done_q <= 1'b1;
              fb_sel_q     <= ~fb_sel_q;
            end else begin
              frame_err_q  <= 1'b1;
            end
          end
`endif
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign fb_wdata   = fb_wdata_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_we      = fb_we_q;
  assign fb_sel     = fb_sel_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ftdi_frame_packer.sv
// Scoreboard bench for ftdi_frame_packer: stimulus pushes expected write/done/err events derived from
// the framing rules; a negedge monitor pops and compares them against DUT strobes.
module tb_ftdi_frame_packer;

  localparam int WORDS  = 4;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 14;
  localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

  logic              clk_60 = 1'b0;
  logic              rst = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic [DATA_W-1:0] fb_wdata;
  logic [ADDR_W-1:0] fb_waddr;
  logic              fb_we, fb_sel, frame_done, frame_err;

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t  expq[$];
  int   checks = 0;
  int   failures = 0;
  bit   gap_en = 1'b0;
  logic exp_sel = 1'b0;

  ftdi_frame_packer #(.WORDS(WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_60(clk_60), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .fb_wdata(fb_wdata), .fb_waddr(fb_waddr), .fb_we(fb_we), .fb_sel(fb_sel),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk_60 = ~clk_60;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input logic [DATA_W-1:0] data);
    ev_t e;
    e.kind = kind; e.addr = ADDR_W'(addr); e.data = data;
    expq.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the expected-event queue.
  always @(negedge clk_60) begin
    ev_t e;
    if (rst) begin
      exp_sel = 1'b0;
    end else begin
      if (frame_done && frame_err) chk("done_err_overlap", 1, 0);
      if (fb_we) begin
        if (expq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = expq.pop_front();
          chk("write_kind", 32'(EV_WR), 32'(e.kind));
          chk("write_addr", 32'(fb_waddr), 32'(e.addr));
          chk("write_data", 32'(fb_wdata), 32'(e.data));
          chk("write_sel", 32'(fb_sel), 32'(exp_sel));
        end
      end
      if (frame_done) begin
        if (expq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = expq.pop_front();
          chk("done_kind", 32'(EV_DONE), 32'(e.kind));
          exp_sel = ~exp_sel;
          chk("done_sel", 32'(fb_sel), 32'(exp_sel));
        end
      end
      if (frame_err) begin
        if (expq.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = expq.pop_front();
          chk("err_kind", 32'(EV_ERR), 32'(e.kind));
          chk("err_sel", 32'(fb_sel), 32'(exp_sel));
        end
      end
    end
  end

  task automatic put(input logic [7:0] b);
    if (gap_en)
      while ($urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
        @(posedge clk_60); #1;
      end
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk_60); #1;
    byte_valid = 1'b0;
  endtask

  // bad_word < 0 means all words are clean.
  task automatic send_frame(input int nlead, input int bad_word, input bit det, input bit csum_bad);
    logic [7:0]  x, b2;
    logic [19:0] p;
    x = 8'h00;
    repeat (nlead) put(8'hA5);
    put(8'hA5);
    put(8'h5A);
    for (int w = 0; w < WORDS; w++) begin
      if (det) p = {4'(3*w+3), 8'(3*w+2), 8'(3*w+1)};
      else     p = 20'($urandom);
      b2 = {4'h0, p[19:16]};
      if (w == bad_word) begin
        b2 = 8'h13;
        push_ev(EV_ERR, 0, '0);
      end else begin
        push_ev(EV_WR, w, p);
      end
      put(p[7:0]);
      put(p[15:8]);
      put(b2);
      x = x ^ p[7:0] ^ p[15:8] ^ b2;
      if (w == bad_word) return;
    end
`ifdef FTDI_PACKER_CHECKSUM_EN
    push_ev(csum_bad ? EV_ERR : EV_DONE, 0, '0);
    put(x ^ {7'd0, csum_bad});
`else
    if (csum_bad) x = 8'h00;
    push_ev(EV_DONE, 0, '0);
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk_60); #1;
      n++;
    end
    chk("drain_pending", 32'(expq.size()), 0);
    repeat (4) @(posedge clk_60);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_60);
    #1;
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_sel", 32'(fb_sel), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_addr", 32'(fb_waddr), 0);
    chk("rst_data", 32'(fb_wdata), 0);
    rst = 1'b0;
    @(posedge clk_60); #1;

    send_frame(0, -1, 1'b1, 1'b0);          // 01 02 03 .. 0C
    drain();
    chk("sel_after_first", 32'(fb_sel), 1);

    send_frame(0, -1, 1'b0, 1'b0);          // back-to-back pair
    send_frame(0, -1, 1'b0, 1'b0);
    drain();

    send_frame(2, -1, 1'b0, 1'b0);          // A5 A5 A5 5A header
    drain();

    put(8'hA5); put(8'h00); put(8'h5A);     // broken header: payload must be ignored
    for (int i = 1; i <= 3*WORDS; i++) put(8'(i));
    drain();

    send_frame(0, 1, 1'b1, 1'b0);           // 0x13 in word 1
    drain();
    send_frame(0, -1, 1'b0, 1'b0);
    drain();

`ifdef FTDI_PACKER_CHECKSUM_EN
    send_frame(0, -1, 1'b0, 1'b1);          // wrong check byte
    drain();
`endif

    gap_en = 1'b1;
    send_frame(0, -1, 1'b1, 1'b0);
    repeat (3) send_frame(0, -1, 1'b0, 1'b0);
    send_frame(0, 2, 1'b0, 1'b0);
    drain();
    gap_en = 1'b0;

    put(8'hA5); put(8'h5A);                 // reset mid-payload
    push_ev(EV_WR, 0, 20'h30201);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    drain();
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(fb_we), 0);
    chk("midrst_sel", 32'(fb_sel), 0);
    chk("midrst_done", 32'(frame_done), 0);
    chk("midrst_err", 32'(frame_err), 0);
    chk("midrst_addr", 32'(fb_waddr), 0);
    repeat (2) @(posedge clk_60);
    #1;
    rst = 1'b0;
    @(posedge clk_60); #1;
    send_frame(0, -1, 1'b1, 1'b0);
    drain();
    chk("final_sel", 32'(fb_sel), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
